scs8hd_clkgate_ctrl: RTL and testbench

Parametrised multi-channel clock-gating controller, the next generation of the single latch-based integrated clock gate. It drives NCH gated clocks from one root clock. Each channel opens on demand, holds its clock for a programmable idle window after activity stops, then closes automatically. It sits between the clock tree root and per-block clock domains, and provides a scan test override and per-channel "clock running" acknowledge.

---
 rtl/scs8hd_clkgate_ctrl_if.sv | 22 ++
 rtl/scs8hd_clkgate_ctrl.sv | 76 +++++++
 tb/tb_scs8hd_clkgate_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/scs8hd_clkgate_ctrl_if.sv
// scs8hd_clkgate_ctrl_if: control and gated-clock bundle for the
// multi-channel clock-gating controller.
interface scs8hd_clkgate_ctrl_if #(
    parameter int NCH = 4
);
    logic           TE;
    logic [NCH-1:0] EN;
    logic [NCH-1:0] REQ;
    logic [NCH-1:0] GCLK;
    logic [NCH-1:0] ACK;
    logic           ALL_OFF;

    modport master (
        output TE, EN, REQ,
        input  GCLK, ACK, ALL_OFF
    );

    modport slave (
        input  TE, EN, REQ,
        output GCLK, ACK, ALL_OFF
    );
endinterface

// File: rtl/scs8hd_clkgate_ctrl.sv
// scs8hd_clkgate_ctrl: NCH gated clocks from one root clock, each held
// open for an idle window after activity, with scan override.
module scs8hd_clkgate_ctrl #(
    parameter int NCH         = 4,
    parameter int IDLE_CYCLES = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    scs8hd_clkgate_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_ON    = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(IDLE_CYCLES - 1);

    logic [1:0]       state [NCH];
    logic [CNT_W-1:0] cnt   [NCH];
    logic [NCH-1:0]   gate_en;
    logic [NCH-1:0]   latch_q;

    // Per-channel OFF/ON/DRAIN sequencing with idle countdown
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NCH; i++) begin
            if (RESET) begin
                state[i] <= ST_OFF;
                cnt[i]   <= '0;
            end else begin
                unique case (state[i])
                    ST_OFF: begin
                        if (bus.EN[i] && bus.REQ[i])
                            state[i] <= ST_ON;
                    end
                    ST_ON: begin
                        if (!bus.EN[i]) begin
                            state[i] <= ST_OFF;
                        end else if (!bus.REQ[i]) begin
                            state[i] <= ST_DRAIN;
                            cnt[i]   <= RELOAD;
                        end
                    end
                    ST_DRAIN: begin
                        if (!bus.EN[i])
                            state[i] <= ST_OFF;
                        else if (bus.REQ[i])
                            state[i] <= ST_ON;
                        else if (cnt[i] == '0)
                            state[i] <= ST_OFF;
                        else
                            cnt[i] <= cnt[i] - 1'b1;
                    end
                    default: state[i] <= ST_OFF;
                endcase
            end
        end
    end

    // Gate enable decoded purely from state registers
    always_comb begin
        gate_en = '0;
        for (int i = 0; i < NCH; i++)
            gate_en[i] = (state[i] != ST_OFF);
    end

    // Low-phase transparent latch keeps the gate stable while CLK is high
    always_latch begin
        if (!CLK)
            latch_q <= gate_en | {NCH{bus.TE}};
    end

    assign bus.GCLK    = {NCH{CLK}} & latch_q;
    assign bus.ACK     = gate_en;
    assign bus.ALL_OFF = ~|gate_en;
endmodule

// File: tb/tb_scs8hd_clkgate_ctrl.sv
// tb_scs8hd_clkgate_ctrl: scoreboard bench with a quiet-time reference
// model for the multi-channel clock-gating controller.
module tb_scs8hd_clkgate_ctrl;
    localparam int NCH  = 8;
    localparam int IDLE = 8;

    typedef struct packed {
        bit             pvld;
        bit             svld;
        bit [NCH-1:0]   gclk;
        bit [NCH-1:0]   ack;
        bit             all_off;
    } exp_t;

    logic CLK;
    logic RESET;

    scs8hd_clkgate_ctrl_if #(.NCH(NCH)) bus ();

    scs8hd_clkgate_ctrl #(
        .NCH         (NCH),
        .IDLE_CYCLES (IDLE)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    bit   open_m [NCH];
    int   quiet  [NCH];
    int   pulses_exp [NCH];
    int   pulses_dut [NCH];
    bit   primed   = 1'b0;
    bit   count_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        always @(posedge bus.GCLK[g])
            if (count_en) pulses_dut[g]++;
    end

    // One cycle: apply inputs in the low phase, predict the next edge
    task automatic step(input bit te, input bit rst,
                        input logic [NCH-1:0] en,
                        input logic [NCH-1:0] req);
        exp_t e;
        @(negedge CLK);
        #1;
        bus.TE  = te;
        RESET   = rst;
        bus.EN  = en;
        bus.REQ = req;
        e = '0;
        e.pvld = primed;
        for (int i = 0; i < NCH; i++) begin
            e.gclk[i] = open_m[i] | te;
            if (primed && e.gclk[i]) pulses_exp[i]++;
        end
        count_en = primed;
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                open_m[i] = 1'b0;
            end else if (!open_m[i]) begin
                if (en[i] && req[i]) begin
                    open_m[i] = 1'b1;
                    quiet[i]  = 0;
                end
            end else if (!en[i]) begin
                open_m[i] = 1'b0;
            end else if (req[i]) begin
                quiet[i] = 0;
            end else begin
                quiet[i]++;
                if (quiet[i] > IDLE) open_m[i] = 1'b0;
            end
        end
        if (rst) primed = 1'b1;
        e.svld = primed;
        for (int i = 0; i < NCH; i++) e.ack[i] = open_m[i];
        e.all_off = (e.ack == '0);
        sb.push_back(e);
    endtask

    // Monitor: compare each edge's outputs against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.pvld) chk("gclk_rise", bus.GCLK, e.gclk);
                if (e.svld) begin
                    chk("ack", bus.ACK, e.ack);
                    chk("all_off", bus.ALL_OFF, e.all_off);
                end
                #3;
                if (e.pvld) chk("gclk_high", bus.GCLK, e.gclk);
                @(negedge CLK);
                #3;
                if (e.pvld) chk("gclk_low", bus.GCLK, '0);
            end
        end
    end

    initial begin
        logic [NCH-1:0] ones;
        logic [NCH-1:0] req;
        logic [NCH-1:0] en;
        bit te;
        bit rst;
        ones = '1;
        for (int i = 0; i < NCH; i++) begin
            open_m[i] = 1'b0;
            quiet[i] = 0;
            pulses_exp[i] = 0;
            pulses_dut[i] = 0;
        end
        RESET   = 1'b1;
        bus.TE  = 1'b0;
        bus.EN  = ones;
        bus.REQ = ones;

        // Reset held with all requests active, then released
        repeat (3) step(1'b0, 1'b1, ones, ones);
        repeat (3) step(1'b0, 1'b0, ones, ones);
        repeat (12) step(1'b0, 1'b0, ones, '0);

        // Single-cycle request on channel 0 and full idle window
        step(1'b0, 1'b0, ones, 8'h01);
        repeat (12) step(1'b0, 1'b0, ones, '0);

        // Drain cancel on channel 1
        repeat (2) step(1'b0, 1'b0, ones, 8'h02);
        repeat (4) step(1'b0, 1'b0, ones, '0);
        repeat (6) step(1'b0, 1'b0, ones, 8'h02);
        repeat (12) step(1'b0, 1'b0, ones, '0);

        // Permit drop mid-drain on channel 2, channel 3 kept busy
        repeat (2) step(1'b0, 1'b0, ones, 8'h0c);
        repeat (3) step(1'b0, 1'b0, ones, 8'h08);
        step(1'b0, 1'b0, 8'hfb, 8'h08);
        repeat (3) step(1'b0, 1'b0, ones, 8'h08);
        repeat (12) step(1'b0, 1'b0, ones, '0);

        // Scan override during reset, then back to normal gating
        repeat (4) step(1'b1, 1'b1, ones, ones);
        repeat (2) step(1'b0, 1'b1, ones, ones);
        repeat (3) step(1'b0, 1'b0, ones, 8'h10);
        repeat (3) step(1'b1, 1'b0, ones, '0);
        repeat (12) step(1'b0, 1'b0, ones, '0);

        // Randomised traffic with alternating request density
        for (int c = 0; c < 10000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            te  = ($urandom_range(0, 49) == 0);
            en  = ~($urandom & $urandom & $urandom);
            if ((c / 1000) % 2 == 0)
                req = $urandom & $urandom & $urandom & $urandom;
            else
                req = $urandom;
            step(te, rst, en, req);
        end

        repeat (2) step(1'b0, 1'b0, ones, '0);
        @(posedge CLK);
        #2;
        count_en = 1'b0;
        @(posedge CLK);
        #5;

        for (int i = 0; i < NCH; i++)
            chk($sformatf("pulse_count_%0d", i), pulses_dut[i], pulses_exp[i]);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
